// File: rtl/memory_unit_if.sv
// memory_unit_if: decoder-side bus into the register file / ALU write-back block.
interface memory_unit_if;
  logic       read_enable;
  logic       write_enable;
  logic [4:0] address;
  logic [7:0] data_input;
  logic [1:0] alu_function_select;
  logic [3:0] flag_registers;
  logic [7:0] output_data;
  logic [3:0] status_flags;
  modport master (
    output read_enable, write_enable, address, data_input, alu_function_select, flag_registers,
    input  output_data, status_flags
  );
  modport slave (
    input  read_enable, write_enable, address, data_input, alu_function_select, flag_registers,
    output output_data, status_flags
  );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: 32x8 register file with optional ALU write-back and {Z,N,C,V} flags.
// Define MEMORY_UNIT_ALU_EN to build the ALU; otherwise every write stores data_input.
module memory_unit (
  input logic clk,
  input logic rst_n,
  memory_unit_if.slave bus
);
  logic [7:0] r [32];
  logic [7:0] a, b, wdata;
  assign a = r[bus.address];
  assign b = bus.data_input;
`ifdef MEMORY_UNIT_ALU_EN
  logic [8:0] res;
  logic       v, c, alu_wb;
  logic [3:0] sf;
  assign alu_wb = bus.flag_registers[1];
  always_comb begin
    res = bus.alu_function_select == 2'd0 ? {1'b0, a} + {1'b0, b} + {8'b0, bus.flag_registers[0]} :
          bus.alu_function_select == 2'd1 ? {1'b0, a} - {1'b0, b} :
          bus.alu_function_select == 2'd2 ? {1'b0, a & b} : {1'b0, a | b};
    // bit 8 of the 9-bit subtract is the borrow
    c = bus.alu_function_select[1] ? 1'b0 : res[8];
    v = bus.alu_function_select == 2'd0 ? (a[7] == b[7]) && (res[7] != a[7]) :
        bus.alu_function_select == 2'd1 ? (a[7] != b[7]) && (res[7] != a[7]) : 1'b0;
    wdata = alu_wb ? res[7:0] : b;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sf <= 4'b0;
    else if (bus.write_enable && alu_wb) sf <= {res[7:0] == 8'd0, res[7], c, v};
  assign bus.status_flags = sf;
`else
  assign wdata = b;
  assign bus.status_flags = 4'b0000;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r[i] <= 8'd0;
      bus.output_data <= 8'd0;
    end else begin
      if (bus.write_enable) r[bus.address] <= wdata;
      if (bus.read_enable) bus.output_data <= a;
    end
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed checks of load/read, ALU write-back, collision and async reset.
module tb_memory_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  memory_unit_if bus ();
  memory_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] ad, input logic [7:0] d, input logic [3:0] fl, input logic [1:0] fs);
    bus.write_enable = 1'b1;
    bus.address = ad;
    bus.data_input = d;
    bus.flag_registers = fl;
    bus.alu_function_select = fs;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.flag_registers = 4'b0;
  endtask
  task automatic rd(input logic [4:0] ad, input logic [7:0] exp, input string tag);
    bus.read_enable = 1'b1;
    bus.address = ad;
    @(posedge clk);
    #1;
    bus.read_enable = 1'b0;
    chk(tag, bus.output_data, exp);
  endtask
  initial begin
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = 5'd0;
    bus.data_input = 8'd0;
    bus.alu_function_select = 2'd0;
    bus.flag_registers = 4'd0;
    #12;
    chk("reset_out", bus.output_data, 8'h00);
    chk("reset_flags", {4'b0, bus.status_flags}, 8'h00);
    rst_n = 1'b1;
    wr(5'd4, 8'h8D, 4'b0000, 2'd0);
    wr(5'd6, 8'hD0, 4'b0000, 2'd0);
    wr(5'd8, 8'h20, 4'b0000, 2'd0);
    rd(5'd4, 8'h8D, "load_r4");
    rd(5'd6, 8'hD0, "load_r6");
    rd(5'd8, 8'h20, "load_r8");
    bus.address = 5'd4;
    @(posedge clk);
    #1;
    chk("hold_out", bus.output_data, 8'h20);
`ifdef MEMORY_UNIT_ALU_EN
    wr(5'd4, 8'hD0, 4'b0010, 2'd0);
    chk("add_flags", {4'b0, bus.status_flags}, 8'h03);
    rd(5'd4, 8'h5D, "add_r4");
    wr(5'd4, 8'h8D, 4'b0000, 2'd0);
    chk("plain_wr_holds_flags", {4'b0, bus.status_flags}, 8'h03);
    wr(5'd4, 8'hD0, 4'b0011, 2'd0);
    rd(5'd4, 8'h5E, "addc_r4");
    chk("addc_flags", {4'b0, bus.status_flags}, 8'h03);
    wr(5'd8, 8'h20, 4'b0010, 2'd1);
    chk("sub_zero_flags", {4'b0, bus.status_flags}, 8'h08);
    rd(5'd8, 8'h00, "sub_zero_r8");
    wr(5'd8, 8'h01, 4'b0010, 2'd1);
    chk("sub_borrow_flags", {4'b0, bus.status_flags}, 8'h06);
    rd(5'd8, 8'hFF, "sub_borrow_r8");
    wr(5'd6, 8'h3F, 4'b0010, 2'd2);
    chk("and_flags", {4'b0, bus.status_flags}, 8'h00);
    rd(5'd6, 8'h10, "and_r6");
    wr(5'd6, 8'h0F, 4'b0010, 2'd3);
    chk("or_flags", {4'b0, bus.status_flags}, 8'h00);
    rd(5'd6, 8'h1F, "or_r6");
    wr(5'd10, 8'h80, 4'b0010, 2'd0);
    chk("add_neg_flags", {4'b0, bus.status_flags}, 8'h04);
`else
    wr(5'd4, 8'hD0, 4'b0010, 2'd0);
    rd(5'd4, 8'hD0, "noalu_r4");
    wr(5'd8, 8'h01, 4'b0011, 2'd1);
    rd(5'd8, 8'h01, "noalu_r8");
    chk("noalu_flags", {4'b0, bus.status_flags}, 8'h00);
`endif
    wr(5'd4, 8'h8D, 4'b0000, 2'd0);
    bus.read_enable = 1'b1;
    wr(5'd4, 8'h11, 4'b0000, 2'd0);
    bus.read_enable = 1'b0;
    chk("collide_old", bus.output_data, 8'h8D);
    rd(5'd4, 8'h11, "collide_new");
    wr(5'd4, 8'h8D, 4'b0000, 2'd0);
    wr(5'd6, 8'hD0, 4'b0000, 2'd0);
    wr(5'd8, 8'h20, 4'b0000, 2'd0);
    rd(5'd4, 8'h8D, "pre_reset_r4");
    #2;
    bus.write_enable = 1'b1;
    bus.address = 5'd4;
    bus.data_input = 8'h55;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", bus.output_data, 8'h00);
    chk("async_rst_flags", {4'b0, bus.status_flags}, 8'h00);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    rst_n = 1'b1;
    rd(5'd4, 8'h00, "post_rst_r4");
    rd(5'd6, 8'h00, "post_rst_r6");
    rd(5'd8, 8'h00, "post_rst_r8");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
